otter_cu_fsm: RTL and testbench
===============================

// Module: otter_cu_fsm
// PURPOSE
//  Multicycle sequencer for the OTTER core. Owns the FETCH/EXEC/WRITEBACK/INTR state machine and drives
//  the write/read strobes of the PC, register file, memory and CSR file.
//  Sits beside the combinational decoder, which selects datapath muxes; this block decides when writes happen.
//  Also keeps a retired-instruction counter.
// PARAMETERS
//  CNT_W        32  width of instret counter
//  SYNC_STAGES  2   flops in the intr synchronizer (>=2)
// PORTS
//  clk        in   1      core clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  ir6_0      in   7      opcode of current instruction
//  ir14_12    in   3      funct3 of current instruction
//  intr       in   1      external interrupt request, asynchronous level
//  csr_mie    in   1      global interrupt enable from CSR file
//  mem_rdy    in   1      load data valid on memory port 2
//  pc_write   out  1      PC register load enable
//  reg_write  out  1      register file write enable
//  mem_we2    out  1      data memory write strobe
//  mem_rden1  out  1      instruction memory read strobe
//  mem_rden2  out  1      data memory read strobe
//  csr_we     out  1      CSR file write enable
//  int_taken  out  1      interrupt entry (to decoder/CSR: save PC, vector)
//  mret_exec  out  1      mret retiring (CSR restores MIE)
//  instret    out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - State is registered; strobes decode combinationally from state + ir6_0/ir14_12. Unlisted strobes are 0.
//  - Reset: state=ST_INIT, instret=0, all strobes 0. Asynchronous; assertion mid-instruction aborts with no write.
//  - ST_INIT: all strobes 0 -> ST_FETCH (one cycle).
//  - ST_FETCH: mem_rden1=1 -> ST_EXEC.
//  - ST_EXEC, by opcode:
//     LOAD 0000011: mem_rden2=1 -> ST_WB (no pc_write).
//     STORE 0100011: mem_we2=1, pc_write=1.
//     BRANCH 1100011: pc_write=1, reg_write=0.
//     SYSTEM 1110011: funct3!=000 -> csr_we=1, reg_write=1; funct3==000 -> mret_exec=1; pc_write=1 in both.
//     OP/OP-IMM/LUI/AUIPC/JAL/JALR: pc_write=1, reg_write=1.
//     Illegal opcode: pc_write=1 only (NOP), still counts as retired.
//  - ST_WB: mem_rden2=1 held. When mem_rdy=0, hold state, all writes 0.
//    When mem_rdy=1: reg_write=1, pc_write=1, retire.
//  - Retire = cycle with pc_write=1 in ST_EXEC/ST_WB. Then next = ST_INTR if (intr_s & csr_mie), else ST_FETCH.
//  - ST_INTR: int_taken=1, pc_write=1 -> ST_FETCH. Does not retire.
//  - Interrupts are checked only at retire. intr arriving during fetch, execute or a WB stall waits for the retire.
//    csr_mie is sampled in the retire cycle; mret retiring with intr_s=1 uses that cycle's csr_mie.
//  - intr_s = intr after SYNC_STAGES flops (reset to 0). Level-sensitive; the source holds intr until serviced.
//  - instret += 1 on each retire. Modulo 2^CNT_W: all-ones wraps to 0, no flag.
//  - Exactly one of pc_write sources is active per cycle. Never mem_we2 & mem_rden2 together.
// CONFIGURATION
//  OTTER_INTR_EN defined: synchronizer and ST_INTR present as above.
//  Undefined: no synchronizer, ST_INTR absent, retire always -> ST_FETCH.
//    int_taken tied 0; intr and csr_mie ignored.
// STRUCTURE
//  otter_pkg: opcode localparams, typedef enum logic [2:0] cu_state_t
//    {ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_INTR}.
//  Sub-module otter_sync #(.STAGES) (clk, rst_n, d, q): intr synchronizer, instantiated only under OTTER_INTR_EN.
// TESTING
//  1 rst_n=0 -> all strobes 0, instret=0. Release -> 1 cycle ST_INIT, then mem_rden1=1.
//  2 addi (0010011) stream -> 2 cycles/instr: EXEC pc_write=reg_write=1; instret 0->1->2.
//  3 lw, mem_rdy=0 for 3 cycles then 1 -> WB holds 3 cycles with writes 0.
//    Then exactly one reg_write+pc_write; instret +1.
//  4 sw -> mem_we2=1, reg_write=0. beq -> pc_write=1, reg_write=0.
//    csrrw (funct3=001) -> csr_we=reg_write=1. mret -> mret_exec=1.
//  5 OTTER_INTR_EN, intr=1, csr_mie=1 during addi EXEC (after sync) -> next cycle ST_INTR with int_taken=1, pc_write=1.
//    instret unchanged by the ST_INTR cycle. With csr_mie=0 -> ST_FETCH, no int_taken.
//    Without macro -> int_taken never 1.
//  6 CNT_W=4: 16 retires -> instret 15->0. rst_n pulsed during ST_WB -> strobes 0 at once, state ST_INIT, instret 0.

Source files
------------

// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - opcode constants and sequencer state type for the OTTER control unit
package otter_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_INTR
  } cu_state_t;

endpackage

// File: rtl/otter_sync.sv
// rtl/otter_sync.sv - multi-flop synchronizer for an asynchronous level input
module otter_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/otter_cu_fsm.sv
// rtl/otter_cu_fsm.sv - OTTER multicycle sequencer: write/read strobes and retired-instruction counter
// Optional interrupt path (synchronizer + ST_INTR) built only when OTTER_INTR_EN is defined.
module otter_cu_fsm
  import otter_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       ir6_0,
  input  logic [2:0]       ir14_12,
  input  logic             intr,
  input  logic             csr_mie,
  input  logic             mem_rdy,
  output logic             pc_write,
  output logic             reg_write,
  output logic             mem_we2,
  output logic             mem_rden1,
  output logic             mem_rden2,
  output logic             csr_we,
  output logic             int_taken,
  output logic             mret_exec,
  output logic [CNT_W-1:0] instret
);

  cu_state_t        state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic             take_intr;

`ifdef OTTER_INTR_EN
  logic intr_s;

  otter_sync #(.STAGES(SYNC_STAGES)) u_intr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (intr),
    .q     (intr_s)
  );

  assign take_intr = intr_s & csr_mie;
`else
  logic unused_intr;
  assign unused_intr = ^{intr, csr_mie};
  assign take_intr   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    retire    = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    mem_we2   = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    csr_we    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;

    case (state_q)
      ST_INIT: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_rden1 = 1'b1;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        // Loads defer their register write and retire to ST_WB.
        if (ir6_0 == OP_LOAD) begin
          mem_rden2 = 1'b1;
          state_d   = ST_WB;
        end else begin
          pc_write = 1'b1;
          retire   = 1'b1;
          case (ir6_0)
            OP_STORE: mem_we2 = 1'b1;
            OP_SYSTEM: begin
              if (ir14_12 != 3'b000) begin
                csr_we    = 1'b1;
                reg_write = 1'b1;
              end else begin
                mret_exec = 1'b1;
              end
            end
            OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: reg_write = 1'b1;
            default: ;
          endcase
        end
      end
      ST_WB: begin
        mem_rden2 = 1'b1;
        if (mem_rdy) begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          retire    = 1'b1;
        end
      end
`ifdef OTTER_INTR_EN
      ST_INTR: begin
        int_taken = 1'b1;
        pc_write  = 1'b1;
        state_d   = ST_FETCH;
      end
`endif
      default: state_d = ST_INIT;
    endcase

    // Interrupts are only ever entered on an instruction boundary.
    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
      state_d   = take_intr ? ST_INTR : ST_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// tb/tb_otter_cu_fsm.sv - self-checking bench for otter_cu_fsm (honours OTTER_INTR_EN)
module tb_otter_cu_fsm;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    ir6_0 = '0;
  logic [2:0]    ir14_12 = '0;
  logic          intr = 1'b0;
  logic          csr_mie = 1'b0;
  logic          mem_rdy = 1'b0;
  logic          pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, csr_we, int_taken, mret_exec;
  logic [CW-1:0] instret;

  otter_cu_fsm #(.CNT_W(CW), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ir6_0     (ir6_0),
    .ir14_12   (ir14_12),
    .intr      (intr),
    .csr_mie   (csr_mie),
    .mem_rdy   (mem_rdy),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .mem_we2   (mem_we2),
    .mem_rden1 (mem_rden1),
    .mem_rden2 (mem_rden2),
    .csr_we    (csr_we),
    .int_taken (int_taken),
    .mret_exec (mret_exec),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, csr_we, int_taken, mret_exec;
  } strb_t;

  typedef struct packed {
    strb_t         s;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // model state
  logic [6:0]    cur_op = '0;
  logic [2:0]    cur_f3 = '0;
  logic          intr_drv = 1'b0, mie_drv = 1'b0, rdy_drv = 1'b0;
  logic          h1 = 1'b0, h2 = 1'b0, cur_intr_s = 1'b0;
  logic [CW-1:0] model_ret = '0;

  function automatic strb_t mk(input logic pc, rg, we, r1, r2, cs, it, mr);
    return '{pc, rg, we, r1, r2, cs, it, mr};
  endfunction

  // Execute-cycle strobes from the opcode table.
  function automatic strb_t exec_strobes(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0000011: return mk(0, 0, 0, 0, 1, 0, 0, 0);
      7'b0100011: return mk(1, 0, 1, 0, 0, 0, 0, 0);
      7'b1100011: return mk(1, 0, 0, 0, 0, 0, 0, 0);
      7'b1110011: return (f3 != 3'b000) ? mk(1, 1, 0, 0, 0, 1, 0, 0) : mk(1, 0, 0, 0, 0, 0, 0, 1);
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111:
        return mk(1, 1, 0, 0, 0, 0, 0, 0);
      default: return mk(1, 0, 0, 0, 0, 0, 0, 0);
    endcase
  endfunction

  task automatic pin(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock cycle: drive inputs, record what this cycle's outputs must be.
  task automatic step(input strb_t e, input logic rst_val);
    exp_t x;
    @(posedge clk);
    #2;
    rst_n   = rst_val;
    ir6_0   = cur_op;
    ir14_12 = cur_f3;
    intr    = intr_drv;
    csr_mie = mie_drv;
    mem_rdy = rdy_drv;
    if (!rst_val) begin
      h1 = 1'b0; h2 = 1'b0; cur_intr_s = 1'b0; model_ret = '0; e = '0;
    end else begin
      cur_intr_s = h2;
    end
    x.s   = e;
    x.ret = model_ret;
    exp_q.push_back(x);
    if (rst_val) begin
      h2 = h1; h1 = intr_drv;
    end
    if (e.pc_write && !e.int_taken) model_ret = model_ret + 1'b1;
  endtask

  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input int stalls,
                          input logic pin_en, input logic [CW-1:0] pin_val);
    cur_op = op; cur_f3 = f3; rdy_drv = 1'b0;
    step(mk(0, 0, 0, 1, 0, 0, 0, 0), 1'b1);
    if (pin_en) begin
      #1 pin("instret_at_fetch", instret, pin_val);
    end
    step(exec_strobes(op, f3), 1'b1);
    if (op == 7'b0000011) begin
      for (int i = 0; i < stalls; i++) step(mk(0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
      rdy_drv = 1'b1;
      step(mk(1, 1, 0, 0, 1, 0, 0, 0), 1'b1);
      rdy_drv = 1'b0;
    end
`ifdef OTTER_INTR_EN
    if (cur_intr_s && mie_drv) begin
      step(mk(1, 0, 0, 0, 0, 0, 1, 0), 1'b1);
      #1 pin("int_taken_literal", {3'b000, int_taken}, 4'd1);
    end
`endif
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      strb_t a;
      e = exp_q.pop_front();
      a = '{pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, csr_we, int_taken, mret_exec};
      checks++;
      if (a !== e.s) begin
        errors++;
        $display("FAIL strobes t=%0t actual=%b required=%b", $time, a, e.s);
      end
      checks++;
      if (instret !== e.ret) begin
        errors++;
        $display("FAIL instret t=%0t actual=%0d required=%0d", $time, instret, e.ret);
      end
      checks++;
      if (mem_we2 && mem_rden2) begin
        errors++;
        $display("FAIL we2_rden2_exclusive t=%0t actual=11 required=not both", $time);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // reset, then exactly one idle ST_INIT cycle before fetch
    repeat (3) step('0, 1'b0);
    #1 pin("instret_reset", instret, 4'd0);
    step('0, 1'b1);

    // addi stream
    do_instr(7'b0010011, 3'b000, 0, 1'b1, 4'd0);
    do_instr(7'b0010011, 3'b000, 0, 1'b0, 4'd0);
    // lw with 3 stall cycles
    do_instr(7'b0000011, 3'b010, 3, 1'b1, 4'd2);
    do_instr(7'b0100011, 3'b010, 0, 1'b1, 4'd3);   // sw
    do_instr(7'b1100011, 3'b000, 0, 1'b0, 4'd0);   // beq
    do_instr(7'b1110011, 3'b001, 0, 1'b1, 4'd5);   // csrrw
    do_instr(7'b1110011, 3'b000, 0, 1'b0, 4'd0);   // mret
    do_instr(7'b1111111, 3'b000, 0, 1'b1, 4'd7);   // illegal
    do_instr(7'b0110111, 3'b000, 0, 1'b1, 4'd8);   // lui
    do_instr(7'b0000011, 3'b000, 0, 1'b1, 4'd9);   // lw, no stall

    // interrupt with csr_mie=1
    intr_drv = 1'b1; mie_drv = 1'b1;
    do_instr(7'b0010011, 3'b000, 0, 1'b0, 4'd0);
    do_instr(7'b0010011, 3'b000, 0, 1'b0, 4'd0);
    intr_drv = 1'b0; mie_drv = 1'b0;
    do_instr(7'b0010011, 3'b000, 0, 1'b0, 4'd0);
    // interrupt held but masked
    intr_drv = 1'b1;
    repeat (3) do_instr(7'b0010011, 3'b000, 0, 1'b0, 4'd0);
    intr_drv = 1'b0;
    repeat (2) do_instr(7'b0010011, 3'b000, 0, 1'b0, 4'd0);
    // mret retiring with a pending, enabled interrupt
    intr_drv = 1'b1; mie_drv = 1'b1;
    do_instr(7'b0010011, 3'b000, 0, 1'b0, 4'd0);
    do_instr(7'b1110011, 3'b000, 0, 1'b0, 4'd0);
    intr_drv = 1'b0; mie_drv = 1'b0;
    repeat (2) do_instr(7'b0010011, 3'b000, 0, 1'b0, 4'd0);

    // reset asserted in the middle of a stalled load
    cur_op = 7'b0000011; cur_f3 = 3'b010; rdy_drv = 1'b0;
    step(mk(0, 0, 0, 1, 0, 0, 0, 0), 1'b1);
    step(mk(0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    step(mk(0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    step('0, 1'b0);
    #1 pin("instret_midwb_reset", instret, 4'd0);
    step('0, 1'b0);
    step('0, 1'b1);

    // counter wrap: 16 retires take a 4-bit counter from 15 back to 0
    for (int i = 0; i < 17; i++)
      do_instr(7'b0110011, 3'b000, 0, (i >= 15), (i == 15) ? 4'd15 : 4'd0);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
